// File: rtl/mem_console_uart.sv
// Console responder for the minrv32 data-memory bus: bytes written to TXDATA
// are queued in a TX FIFO and serialized as 8N1 UART frames on uart_tx.
module mem_console_uart #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  mem_rmask,
    output logic        sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop_c;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shreg_q;
    logic [7:0]    shreg_d;
    logic          tx_d;

    logic [3:0]    offset;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{mem_wdata[31:8], mem_wstrb[3:1]};

    // Bus decode and handshake
    assign offset    = mem_addr[3:0];
    assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign push_req  = sel && (offset == 4'h0) && mem_wstrb[0];
    assign mem_ready = !(push_req && full);
    assign push      = push_req && !full && resetn;

    assign status    = {20'h0, 4'(count_q), 5'h0, (state_q == IDLE), empty, full};
    assign mem_rdata = (sel && (mem_rmask != 4'h0) && (offset == 4'h4)) ? status : 32'h0;

    assign count_d   = count_q + CW'(push) - CW'(pop_c);

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    // Transmitter state register; uart_tx is driven from the next-state value
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            uart_tx <= tx_d;
            tx_busy <= (state_d != IDLE) || (count_d != '0);
        end
    end

    // Transmitter next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = uart_tx;
        pop_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_mem[rd_ptr];
                    timer_d = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_mem[rd_ptr];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_console_uart.sv
// Directed bench for mem_console_uart with CLK_DIV=4 and FIFO_DEPTH=4.
module tb_mem_console_uart;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [3:0]  mem_rmask = '0;
    logic        sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [3:0]  rmask;
        logic        exp_sel;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    mem_console_uart #(
        .BASE_ADDR (BASE),
        .CLK_DIV   (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rmask(mem_rmask),
        .sel      (sel),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        mem_rmask = '0;
    endtask

    // Holds a TXDATA-style write until accepted; returns the number of refused edges
    task automatic do_write(input logic [31:0] a, input logic [7:0] d, output int stalls);
        stalls    = 0;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = {24'hA5A5A5, d};
        mem_wstrb = 4'h1;
        mem_rmask = 4'h0;
        #1;
        while (mem_ready !== 1'b1 && stalls < 200) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = 4'h0;
        mem_rmask = 4'hF;
        #1;
        d = mem_rdata;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    // Checks one 40-cycle frame, starting on the first start-bit cycle
    task automatic check_frame(input logic [7:0] data, input string tag);
        logic exp_b;
        for (int k = 0; k < 40; k++) begin
            if (k < 4) exp_b = 1'b0;
            else if (k < 36) exp_b = data[(k - 4) / 4];
            else exp_b = 1'b1;
            chk(tag, 32'(uart_tx), 32'(exp_b));
            if (k == 39) chk({tag, " busy at frame end"}, 32'(tx_busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          st;
        int          lows;

        vecs[0]  = '{1'b1, 32'h1000_0004, 4'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0006};
        vecs[1]  = '{1'b1, 32'h1000_0000, 4'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b1, 32'h1000_0008, 4'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 32'h1000_000C, 4'h0, 4'hF, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 32'h1000_0008, 4'hF, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h1000_0000, 4'h2, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h1000_0004, 4'h0, 4'h1, 1'b1, 1'b1, 32'h0000_0006};
        vecs[7]  = '{1'b1, 32'h1000_0004, 4'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'h1000_0010, 4'h0, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0004, 4'h0, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h1000_0004, 4'h0, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b1, 32'h1000_0000, 4'hE, 4'h0, 1'b1, 1'b1, 32'h0000_0000};

        // Reset state
        idle_bus();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("reset uart_tx", 32'(uart_tx), 32'd1);
        chk("reset tx_busy", 32'(tx_busy), 32'd0);
        read_reg(BASE + 32'h4, rd);
        chk("reset status", rd, 32'h0000_0006);

        // Single-cycle register accesses on an idle block
        foreach (vecs[i]) begin
            mem_valid = vecs[i].valid;
            mem_addr  = vecs[i].addr;
            mem_wdata = 32'h0000_00AA;
            mem_wstrb = vecs[i].wstrb;
            mem_rmask = vecs[i].rmask;
            #1;
            chk($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].exp_sel));
            if (vecs[i].exp_sel) chk($sformatf("vec%0d ready", i), 32'(mem_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d rdata", i), mem_rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            idle_bus();
        end
        repeat (3) tick();
        chk("no push: uart_tx", 32'(uart_tx), 32'd1);
        chk("no push: tx_busy", 32'(tx_busy), 32'd0);
        read_reg(BASE + 32'h4, rd);
        chk("no push: status", rd, 32'h0000_0006);

        // Single byte 0x55: start bit one edge after the push edge, 40-cycle frame
        do_write(BASE, 8'h55, st);
        chk("0x55 stalls", 32'(st), 32'd0);
        chk("0x55 tx before pop", 32'(uart_tx), 32'd1);
        chk("0x55 busy after push", 32'(tx_busy), 32'd1);
        tick();
        check_frame(8'h55, "frame 0x55");
        chk("0x55 busy after frame", 32'(tx_busy), 32'd0);
        chk("0x55 tx idle", 32'(uart_tx), 32'd1);

        // Six back-to-back bytes: sixth stalls through the full-FIFO pop edge
        fork
            begin
                int stv [6];
                logic [31:0] srd;
                for (int i = 0; i < 6; i++) do_write(BASE, 8'h41 + 8'(i), stv[i]);
                for (int i = 0; i < 5; i++) chk($sformatf("burst write%0d stalls", i + 1), 32'(stv[i]), 32'd0);
                chk("burst write6 stalls", 32'(stv[5]), 32'd37);
                read_reg(BASE + 32'h4, srd);
                chk("burst status after refill", srd, 32'h0000_0401);
            end
            begin
                int w;
                w = 0;
                while (uart_tx !== 1'b0 && w < 20) begin
                    w++;
                    tick();
                end
                chk("burst start seen", 32'(w < 20), 32'd1);
                for (int i = 0; i < 6; i++) check_frame(8'h41 + 8'(i), $sformatf("burst frame%0d", i + 1));
                chk("burst busy after", 32'(tx_busy), 32'd0);
                chk("burst tx idle", 32'(uart_tx), 32'd1);
            end
        join

        // Reset in the middle of frame 2 with three bytes still queued
        for (int i = 0; i < 5; i++) begin
            do_write(BASE, 8'h11 + 8'(i), st);
            chk($sformatf("abort write%0d stalls", i + 1), 32'(st), 32'd0);
        end
        repeat (37) tick();
        chk("abort frame2 start bit", 32'(uart_tx), 32'd0);
        read_reg(BASE + 32'h4, rd);
        chk("abort status frame2", rd, 32'h0000_0300);
        repeat (19) tick();
        resetn    = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'h0000_0077;
        mem_wstrb = 4'h1;
        #1;
        chk("reset held sel", 32'(sel), 32'd1);
        chk("reset held ready", 32'(mem_ready), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_bus();
        chk("abort uart_tx", 32'(uart_tx), 32'd1);
        chk("abort tx_busy", 32'(tx_busy), 32'd0);
        read_reg(BASE + 32'h4, rd);
        chk("abort status", rd, 32'h0000_0006);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (uart_tx !== 1'b1) lows++;
            tick();
        end
        chk("abort no further frames", 32'(lows), 32'd0);
        chk("abort busy stays low", 32'(tx_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
